// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a synchronous instruction RAM.
// Handshake: there is no valid/ready pair; the fetch stage presents Imem_addr every
// cycle and the memory returns mem[Imem_addr] on Imem_dout exactly one cycle later.
interface instr_fetch_stage_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] Imem_addr;
    logic [31:0]       Imem_dout;

    modport master (output Imem_addr, input Imem_dout);
    modport slave  (input Imem_addr, output Imem_dout);
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC register, one in-flight fetch slot (F_pc/F_valid)
// and the instruction register (Instr/Instr_PC/Instr_valid) feeding decode.
// PC_LdEn=0 freezes the whole stage; Flush kills both older slots; a launch
// outside the memory range sets a sticky fault that blocks all later launches.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                PC_LdEn,
    input  logic                PC_sel,
    input  logic [31:0]         PC_Immed,
    input  logic                Flush,
    instr_fetch_stage_if.master imem,
    output logic [31:0]         PC,
    output logic [31:0]         Instr,
    output logic [31:0]         Instr_PC,
    output logic                Instr_valid,
    output logic                Fetch_fault,
    output logic [31:0]         Instr_count
);

    logic [31:0] pc_q;
    logic [31:0] f_pc_q;
    logic        f_valid_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        instr_valid_q;
    logic        fault_q;
    logic [31:0] count_q;

    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        in_range;
    logic        launch_ok;
    logic        capture_ok;

    // Next-PC, range check and slot-qualification logic.
    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        pc_next    = PC_sel ? (pc_plus4 + PC_Immed) : pc_plus4;
        // PC is in range when every byte-address bit above the memory is zero.
        in_range   = (pc_q[31:ADDR_W+2] == '0);
        launch_ok  = ~Flush & ~fault_q & in_range;
        capture_ok = f_valid_q & ~Flush;
    end

    // Address mux: during a stall re-present the in-flight address so the
    // registered memory output still holds mem[F_pc] when the stall ends.
    always_comb begin
        imem.Imem_addr = PC_LdEn ? pc_q[ADDR_W+1:2] : f_pc_q[ADDR_W+1:2];
    end

    // PC register and in-flight fetch slot.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q      <= RESET_PC;
            f_pc_q    <= 32'd0;
            f_valid_q <= 1'b0;
        end else if (PC_LdEn) begin
            pc_q      <= pc_next;
            f_pc_q    <= pc_q;
            f_valid_q <= launch_ok;
        end else if (Flush) begin
            f_valid_q <= 1'b0;
        end
    end

    // Instruction register; data is not cleared on invalidation, only the tag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            instr_valid_q <= 1'b0;
        end else if (PC_LdEn) begin
            instr_q       <= imem.Imem_dout;
            instr_pc_q    <= f_pc_q;
            instr_valid_q <= capture_ok;
        end else if (Flush) begin
            instr_valid_q <= 1'b0;
        end
    end

    // Sticky fetch fault and delivered-instruction counter (wraps at 2^32).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fault_q <= 1'b0;
            count_q <= 32'd0;
        end else if (PC_LdEn) begin
            if (!in_range) begin
                fault_q <= 1'b1;
            end
            if (capture_ok) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // Output drive.
    always_comb begin
        PC          = pc_q;
        Instr       = instr_q;
        Instr_PC    = instr_pc_q;
        Instr_valid = instr_valid_q;
        Fetch_fault = fault_q;
        Instr_count = count_q;
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: a table of per-cycle vectors on a full-size
// instance, plus a hand-written range-fault sequence on a 16-word instance.
module tb_instr_fetch_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (ADDR_W=10)
    logic        rst1, ld1, sel1, fl1;
    logic [31:0] imm1;
    logic [31:0] pc1, instr1, ipc1, cnt1;
    logic        iv1, fault1;
    instr_fetch_stage_if #(.ADDR_W(10)) bus1 ();

    // small instance (ADDR_W=4) for the fault test
    logic        rst2, ld2, sel2, fl2;
    logic [31:0] imm2;
    logic [31:0] pc2, instr2, ipc2, cnt2;
    logic        iv2, fault2;
    instr_fetch_stage_if #(.ADDR_W(4)) bus2 ();

    instr_fetch_stage #(.RESET_PC(32'h0000_0000), .ADDR_W(10)) dut1 (
        .Clk(clk), .Reset(rst1), .PC_LdEn(ld1), .PC_sel(sel1), .PC_Immed(imm1),
        .Flush(fl1), .imem(bus1), .PC(pc1), .Instr(instr1), .Instr_PC(ipc1),
        .Instr_valid(iv1), .Fetch_fault(fault1), .Instr_count(cnt1)
    );

    instr_fetch_stage #(.RESET_PC(32'h0000_0000), .ADDR_W(4)) dut2 (
        .Clk(clk), .Reset(rst2), .PC_LdEn(ld2), .PC_sel(sel2), .PC_Immed(imm2),
        .Flush(fl2), .imem(bus2), .PC(pc2), .Instr(instr2), .Instr_PC(ipc2),
        .Instr_valid(iv2), .Fetch_fault(fault2), .Instr_count(cnt2)
    );

    // Synchronous instruction memories: mem[i] = A000_0000 + i.
    always @(posedge clk) bus1.Imem_dout <= 32'hA000_0000 + 32'(bus1.Imem_addr);
    always @(posedge clk) bus2.Imem_dout <= 32'hA000_0000 + 32'(bus2.Imem_addr);

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst, ld, sel, fl;
        logic [31:0] imm;
        logic [31:0] exp_addr;   // Imem_addr before the edge
        logic [31:0] exp_pc;     // state after the edge
        logic        exp_iv;
        logic        chk_ir;     // Instr/Instr_PC checked only when meaningful
        logic [31:0] exp_instr, exp_ipc, exp_cnt;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic rst, input logic ld, input logic sel, input logic fl,
                                input logic [31:0] imm, input logic [31:0] addr,
                                input logic [31:0] pc, input logic iv, input logic ck,
                                input logic [31:0] ins, input logic [31:0] ipc,
                                input logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.ld = ld; v.sel = sel; v.fl = fl; v.imm = imm;
        v.exp_addr = addr; v.exp_pc = pc; v.exp_iv = iv; v.chk_ir = ck;
        v.exp_instr = ins; v.exp_ipc = ipc; v.exp_cnt = cnt;
        return v;
    endfunction

    // ---------------- driver ----------------
    initial begin
        //            rst ld sel fl imm           addr pc  iv ck instr         ipc cnt
        // sequential start after reset
        vecs[0]  = mk(0, 1, 0, 0, 32'h0,         0,  4,  0, 0, 32'h0,        0,  0);
        vecs[1]  = mk(0, 1, 0, 0, 32'h0,         1,  8,  1, 1, 32'hA000_0000, 0,  1);
        vecs[2]  = mk(0, 1, 0, 0, 32'h0,         2,  12, 1, 1, 32'hA000_0001, 4,  2);
        // 3-cycle stall with PC=8 in flight
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,         2,  12, 1, 1, 32'hA000_0001, 4,  2);
        vecs[4]  = mk(0, 0, 0, 0, 32'h0,         2,  12, 1, 1, 32'hA000_0001, 4,  2);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,         2,  12, 1, 1, 32'hA000_0001, 4,  2);
        vecs[6]  = mk(0, 1, 0, 0, 32'h0,         3,  16, 1, 1, 32'hA000_0002, 8,  3);
        // backward branch with flush at PC=16
        vecs[7]  = mk(0, 1, 1, 1, 32'hFFFF_FFF0, 4,  4,  0, 0, 32'h0,        0,  3);
        vecs[8]  = mk(0, 1, 0, 0, 32'h0,         1,  8,  0, 0, 32'h0,        0,  3);
        vecs[9]  = mk(0, 1, 0, 0, 32'h0,         2,  12, 1, 1, 32'hA000_0001, 4,  4);
        // flush during a stall
        vecs[10] = mk(0, 0, 0, 1, 32'h0,         2,  12, 0, 0, 32'h0,        0,  4);
        vecs[11] = mk(0, 0, 0, 0, 32'h0,         2,  12, 0, 0, 32'h0,        0,  4);
        vecs[12] = mk(0, 1, 0, 0, 32'h0,         3,  16, 0, 0, 32'h0,        0,  4);
        vecs[13] = mk(0, 1, 0, 0, 32'h0,         4,  20, 1, 1, 32'hA000_0003, 12, 5);
        vecs[14] = mk(0, 1, 0, 0, 32'h0,         5,  24, 1, 1, 32'hA000_0004, 16, 6);
        // reset mid-run with flush and branch asserted
        vecs[15] = mk(1, 1, 1, 1, 32'h100,       6,  0,  0, 1, 32'h0,        0,  0);
        vecs[16] = mk(0, 1, 0, 0, 32'h0,         0,  4,  0, 0, 32'h0,        0,  0);
        vecs[17] = mk(0, 1, 0, 0, 32'h0,         1,  8,  1, 1, 32'hA000_0000, 0,  1);
        // forward branch without flush: shadow instruction still delivered
        vecs[18] = mk(0, 1, 1, 0, 32'h20,        2,  44, 1, 1, 32'hA000_0001, 4,  2);
        vecs[19] = mk(0, 1, 0, 0, 32'h0,         11, 48, 1, 1, 32'hA000_0002, 8,  3);
        vecs[20] = mk(0, 1, 0, 0, 32'h0,         12, 52, 1, 1, 32'hA000_000B, 44, 4);
        // negative offset wrapping through 2^32 back to 0
        vecs[21] = mk(0, 1, 1, 0, 32'hFFFF_FFC8, 13, 0,  1, 1, 32'hA000_000C, 48, 5);
        vecs[22] = mk(0, 1, 0, 0, 32'h0,         0,  4,  1, 1, 32'hA000_000D, 52, 6);

        // reset both instances
        rst1 = 1; ld1 = 1; sel1 = 0; fl1 = 0; imm1 = 0;
        rst2 = 1; ld2 = 1; sel2 = 0; fl2 = 0; imm2 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc",    pc1, 32'h0);
        check("reset_iv",    32'(iv1), 32'h0);
        check("reset_instr", instr1, 32'h0);
        check("reset_ipc",   ipc1, 32'h0);
        check("reset_cnt",   cnt1, 32'h0);
        check("reset_fault", 32'(fault1), 32'h0);
        check("reset_fault2", 32'(fault2), 32'h0);

        // apply the table, one vector per cycle
        for (int i = 0; i < 23; i++) begin
            rst1 = vecs[i].rst; ld1 = vecs[i].ld; sel1 = vecs[i].sel;
            fl1 = vecs[i].fl; imm1 = vecs[i].imm;
            #1;
            check($sformatf("v%0d_addr", i), 32'(bus1.Imem_addr), vecs[i].exp_addr);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pc", i), pc1, vecs[i].exp_pc);
            check($sformatf("v%0d_iv", i), 32'(iv1), 32'(vecs[i].exp_iv));
            if (vecs[i].chk_ir) begin
                check($sformatf("v%0d_instr", i), instr1, vecs[i].exp_instr);
                check($sformatf("v%0d_ipc", i), ipc1, vecs[i].exp_ipc);
            end
            check($sformatf("v%0d_cnt", i), cnt1, vecs[i].exp_cnt);
            check($sformatf("v%0d_fault", i), 32'(fault1), 32'h0);
        end

        // fetch-range fault on the 16-word instance: PC=64 launches at edge 17
        rst2 = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (e == 16) check("flt_pre", 32'(fault2), 32'h0);
            if (e == 17) begin
                check("flt_set",       32'(fault2), 32'h1);
                check("flt_last_iv",   32'(iv2), 32'h1);
                check("flt_last_ipc",  ipc2, 32'd60);
                check("flt_last_ins",  instr2, 32'hA000_000F);
                check("flt_last_cnt",  cnt2, 32'd16);
            end
            if (e == 18) check("flt_iv_off", 32'(iv2), 32'h0);
            if (e == 20) begin
                check("flt_pc_adv", pc2, 32'd80);
                check("flt_sticky", 32'(fault2), 32'h1);
                check("flt_iv_hold", 32'(iv2), 32'h0);
                check("flt_cnt_hold", cnt2, 32'd16);
            end
        end
        rst2 = 1;
        @(posedge clk);
        #1;
        check("flt_rst_clear", 32'(fault2), 32'h0);
        check("flt_rst_pc",    pc2, 32'h0);
        check("flt_rst_cnt",   cnt2, 32'h0);
        rst2 = 0;
        @(posedge clk);
        #1;
        check("flt_rst_iv1", 32'(iv2), 32'h0);
        @(posedge clk);
        #1;
        check("flt_rst_iv2",  32'(iv2), 32'h1);
        check("flt_rst_ipc",  ipc2, 32'h0);
        check("flt_rst_ins",  instr2, 32'hA000_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction fetch stage of the pipelined datapath. It holds the PC, computes the next PC (sequential or PC-relative branch using the word-aligned offset from the immediate extender, already SignExtend(Imm)<<2), and drives a synchronous instruction memory. The returned word is captured into an instruction register with PC and valid tags, which feeds decode and the immediate extender. Supports stall, flush, a fetch-range fault and a delivered-instruction counter.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ADDR_W, 10, instruction memory word-address width; valid byte range is 0 .. 4*2^ADDR_W-1

- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high
- PC_LdEn  in  1  1 = advance pipeline; 0 = stall, all state held
- PC_sel  in  1  0 = next PC is PC+4; 1 = next PC is PC+4+PC_Immed
- PC_Immed  in  32  branch offset, already sign-extended and shifted left by 2
- Flush  in  1  kill the in-flight fetch and the IR contents
- Imem_addr  out  ADDR_W  word address to instruction memory
- Imem_dout  in  32  memory data, valid one cycle after Imem_addr
- PC  out  32  current PC register
- Instr  out  32  instruction register
- Instr_PC  out  32  byte address of Instr
- Instr_valid  out  1  Instr holds a live instruction
- Fetch_fault  out  1  sticky: a fetch was launched outside memory range
- Instr_count  out  32  number of instructions captured with valid=1

## Operation

- Three state groups: PC register; in-flight fetch (F_pc, F_valid); IR (Instr, Instr_PC, Instr_valid).
- Imem_addr = PC_LdEn ? PC[ADDR_W+1:2] : F_pc[ADDR_W+1:2]. During a stall the in-flight address is re-presented so Imem_dout still holds mem[F_pc] on resume. PC[1:0] is ignored.
- When PC_LdEn=1 each cycle:
  - PC <= PC_sel ? PC+4+PC_Immed : PC+4, modulo 2^32 with wrap and no flag.
  - F_pc <= PC.
  - F_valid <= ~Flush & ~Fetch_fault & in_range(PC), where in_range(PC) is PC < 4*2^ADDR_W.
  - Instr <= Imem_dout, Instr_PC <= F_pc, Instr_valid <= F_valid & ~Flush.
  - Instr_count increments by 1 when F_valid & ~Flush. It wraps at 2^32.
- When PC_LdEn=0: PC, F_pc, Instr, Instr_PC and Instr_count hold. If Flush=1, F_valid and Instr_valid are cleared.
- Fault: when a launch has ~in_range(PC) and Fetch_fault=0, Fetch_fault <= 1. It stays set until Reset. After that no launch is valid, but the PC keeps advancing.
- Flush and PC_sel may be asserted in the same cycle; this is the normal branch-redirect case. The target PC loads and both older slots are invalidated.
- Instr is not cleared when invalidated. Consumers qualify it with Instr_valid.

## Timing

- Reset values: PC=RESET_PC, F_pc=0, F_valid=0, Instr=0, Instr_PC=0, Instr_valid=0, Fetch_fault=0, Instr_count=0. Reset overrides PC_LdEn and Flush.
- Latency: a PC launched at edge t appears on Instr with Instr_valid=1 after edge t+2, assuming no stall. Each stall cycle adds one cycle.
- First cycle after Reset deasserts: Imem_addr=RESET_PC>>2. Instr_valid first rises two edges later.
- Branch penalty: a redirect with Flush discards exactly two sequential fetches.
- Throughput: one instruction per cycle while PC_LdEn=1.
- Imem_addr has a combinational path from PC_LdEn.

## Test plan

- Reset, RESET_PC=0, PC_LdEn=1, mem[i]=32'hA000_0000+i -> Instr_valid rises at the 2nd edge after reset. Instr/Instr_PC then step A000_0000/0, A000_0001/4, A000_0002/8, and Instr_count=3 after 3 valid captures.
- Stall with PC_LdEn=0 for 3 cycles while the instruction from PC=8 is in flight -> Imem_addr=2 during the stall. On resume Instr=A000_0002 and Instr_PC=8, with no duplicate or skipped word.
- At PC=16, assert PC_sel=1, PC_Immed=32'hFFFF_FFF0 (-16) and Flush=1 -> next PC=4. Instr_valid is 0 for 2 cycles, then Instr_PC=4, and Instr_count does not count flushed slots.
- ADDR_W=4, sequential run to PC=64 -> Fetch_fault=1 after the launch edge at PC=64. Instr_PC=60 is the last valid instruction. Fetch_fault stays 1 until Reset, and Reset clears it.
- Flush during a stall -> Instr_valid=0 and F_valid=0 immediately. PC is unchanged. On resume the first valid instruction has Instr_PC = the PC held during the stall.
- Reset asserted mid-run with Flush=1 and PC_sel=1 -> all outputs take their reset values on that edge, and PC=RESET_PC.
